// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage in-order pipeline.
// Shadows EX/MEM/WB control fields to drive ALU operand muxes and ID stalls.
module forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall_id,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } ex_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
    } wb_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    ex_t              ex_q;
    ex_t              ex_d;
    wb_t              mem_q;
    wb_t              wb_q;
    logic [CNT_W-1:0] cnt_q;

    logic mem_prod;
    logic wb_prod;
    logic ld_hit;

    // Register 0 is hardwired, so a write to it never produces a value.
    assign mem_prod = mem_q.valid & mem_q.reg_write & (|mem_q.dest);
    assign wb_prod  = wb_q.valid & wb_q.reg_write & (|wb_q.dest);

    assign ld_hit = (ex_q.dest == id_rs) | (ex_q.dest == id_rt);

    assign stall_id = id_valid & ~flush & ex_q.valid & ex_q.mem_read
                    & (|ex_q.dest) & ld_hit;

    always_comb begin
        fwd_sel_a = SEL_RF;
        priority case (1'b1)
            !ex_q.valid:                           fwd_sel_a = SEL_RF;
            mem_prod && (mem_q.dest == ex_q.rs):   fwd_sel_a = SEL_MEM;
            wb_prod && (wb_q.dest == ex_q.rs):     fwd_sel_a = SEL_WB;
            default:                               fwd_sel_a = SEL_RF;
        endcase
    end

    always_comb begin
        fwd_sel_b = SEL_RF;
        priority case (1'b1)
            !ex_q.valid:                           fwd_sel_b = SEL_RF;
            mem_prod && (mem_q.dest == ex_q.rt):   fwd_sel_b = SEL_MEM;
            wb_prod && (wb_q.dest == ex_q.rt):     fwd_sel_b = SEL_WB;
            default:                               fwd_sel_b = SEL_RF;
        endcase
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !flush && !stall_id) begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.dest      = id_dest;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q            <= mem_q;
            mem_q.valid     <= ex_q.valid;
            mem_q.dest      <= ex_q.dest;
            mem_q.reg_write <= ex_q.reg_write;
            ex_q            <= ex_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_id && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: forwarding, load-use stall, flush,
// mid-stream reset and counter saturation (second instance, CNT_W=2).
module tb_forward_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dest;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic        stall_id;
    logic [15:0] stall_count;
    logic [1:0]  s_fwd_sel_a;
    logic [1:0]  s_fwd_sel_b;
    logic        s_stall_id;
    logic [1:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    forward_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_id     (stall_id),
        .stall_count  (stall_count)
    );

    forward_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_sel_a    (s_fwd_sel_a),
        .fwd_sel_b    (s_fwd_sel_b),
        .stall_id     (s_stall_id),
        .stall_count  (s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_dest      = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        nop();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic one_stall();
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0);
        tick();
        nop();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        nop();
        #10;
        chk("rst_fwd_a", 32'(fwd_sel_a), 32'd0);
        chk("rst_fwd_b", 32'(fwd_sel_b), 32'd0);
        chk("rst_stall", 32'(stall_id), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // add $3,$1,$2 ; sub $5,$3,$4
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
        tick();
        chk("b2b_fwd_a", 32'(fwd_sel_a), 32'd1);
        chk("b2b_fwd_b", 32'(fwd_sel_b), 32'd0);
        idle(3);

        // add $3 ; nop ; or $6,$3,$3
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0);
        tick();
        chk("dist2_fwd_a", 32'(fwd_sel_a), 32'd2);
        chk("dist2_fwd_b", 32'(fwd_sel_b), 32'd2);
        idle(3);

        // add $3 ; add $3 ; sub $7,$3,$0
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        chk("dbl_fwd_a", 32'(fwd_sel_a), 32'd1);
        chk("dbl_fwd_b", 32'(fwd_sel_b), 32'd0);
        idle(3);

        // add $0,$1,$2 ; or $8,$0,$0 : $0 never forwarded
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        tick();
        chk("r0_fwd_a", 32'(fwd_sel_a), 32'd0);
        chk("r0_fwd_b", 32'(fwd_sel_b), 32'd0);
        idle(3);

        // lw $2,0($1) ; add $4,$2,$1
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0);
        chk("lu_stall", 32'(stall_id), 32'd1);
        chk("lu_count0", 32'(stall_count), 32'd0);
        tick();
        chk("lu_stall_drop", 32'(stall_id), 32'd0);
        chk("lu_count1", 32'(stall_count), 32'd1);
        chk("lu_bubble_a", 32'(fwd_sel_a), 32'd0);
        tick();
        chk("lu_fwd_a", 32'(fwd_sel_a), 32'd2);
        chk("lu_fwd_b", 32'(fwd_sel_b), 32'd0);
        idle(3);

        // same load-use with flush asserted
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        set_id(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0);
        chk("fl_stall", 32'(stall_id), 32'd0);
        tick();
        flush = 1'b0;
        nop();
        chk("fl_count", 32'(stall_count), 32'd1);
        chk("fl_bubble_a", 32'(fwd_sel_a), 32'd0);
        idle(3);

        // load-use through rt: lw $5 ; add $6,$1,$5
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0);
        chk("rt_stall", 32'(stall_id), 32'd1);
        tick();
        chk("rt_count", 32'(stall_count), 32'd2);
        tick();
        chk("rt_fwd_b", 32'(fwd_sel_b), 32'd2);
        idle(3);

        // reset between edges while a load-use stall is pending
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0);
        chk("pre_rst_stall", 32'(stall_id), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_id), 32'd0);
        chk("mid_rst_fwd_a", 32'(fwd_sel_a), 32'd0);
        chk("mid_rst_fwd_b", 32'(fwd_sel_b), 32'd0);
        chk("mid_rst_count", 32'(stall_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", 32'(stall_id), 32'd0);
        tick();
        chk("post_rst_fwd_a", 32'(fwd_sel_a), 32'd0);
        idle(3);

        // five stalls: full counter reaches 5, 2-bit counter holds at 3
        for (int i = 0; i < 5; i++) one_stall();
        chk("sat_full", 32'(stall_count), 32'd5);
        chk("sat_2bit", 32'(s_stall_count), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port id_valid, input, 1, ID stage holds a real instruction.
REQ-006 SHALL have port id_rs, input, REG_AW, ID source register 1.
REQ-007 SHALL have port id_rt, input, REG_AW, ID source register 2.
REQ-008 SHALL have port id_dest, input, REG_AW, ID destination (rd or rt, chosen upstream).
REQ-009 SHALL have port id_reg_write, input, 1, ID instruction writes the register file.
REQ-010 SHALL have port id_mem_read, input, 1, ID instruction is a load.
REQ-011 SHALL have port flush, input, 1, kill the ID instruction (branch taken).
REQ-012 SHALL have port fwd_sel_a, output, 2, ALU operand-1 select: 00 rs_data, 01 EX/MEM ALU result, 10 MEM/WB writeback data; 11 never driven.
REQ-013 SHALL have port fwd_sel_b, output, 2, ALU operand-2 select, same encoding.
REQ-014 SHALL have port stall_id, output, 1, hold PC and IF/ID; load-use hazard.
REQ-015 SHALL have port stall_count, output, CNT_W, number of stall cycles since reset.

Function
REQ-016 SHALL keep three shadow stages (EX, MEM, WB), each holding: valid, rs, rt, dest, reg_write, mem_read (rs, rt, mem_read needed in EX only).
REQ-017 SHALL advance on every clk edge: WB <= MEM; MEM <= EX; EX <= ID fields, or a bubble (valid=0, reg_write=0, mem_read=0) when stall_id=1, flush=1, or id_valid=0.
REQ-018 SHALL drive fwd_sel_a combinationally from registered state, with zero added latency.
- 01 if MEM.valid & MEM.reg_write & MEM.dest!=0 & MEM.dest==EX.rs.
- Else 10 if WB.valid & WB.reg_write & WB.dest!=0 & WB.dest==EX.rs.
- Else 00.
REQ-019 SHALL drive fwd_sel_b identically, using EX.rt.
REQ-020 SHALL give MEM priority over WB when both match (youngest producer wins).
REQ-021 SHALL drive fwd_sel_a and fwd_sel_b to 00 when EX.valid=0.
REQ-022 SHALL never forward register 0 (dest==0 suppresses the match).
REQ-023 SHALL assert stall_id combinationally when all of the following hold: id_valid & ~flush & EX.valid & EX.mem_read & EX.dest!=0, and (EX.dest==id_rs or EX.dest==id_rt).
REQ-024 SHALL produce a load-use stall of exactly one cycle: after the bubble the load sits in MEM, stall_id drops, and the consumer later receives 10 from WB.
REQ-025 SHALL let flush dominate a simultaneous stall: stall_id=0 and a bubble enters EX.
REQ-026 SHALL increment stall_count on each edge where stall_id=1, saturating at all-ones (no wrap).
REQ-027 SHALL make fwd_sel and stall_id depend only on current inputs and registered state, with no combinational loop through stall_id.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear all shadow stages (valid=0, fields=0), stall_count=0, fwd_sel_a=fwd_sel_b=00, stall_id=0.
REQ-029 SHALL resume normal advance on the first rising edge after rst_n deasserts; mid-operation reset discards all in-flight hazard state.

Verification
REQ-030 SHALL cover back-to-back dependency: add $3 then sub $5,$3,$4 -> with sub in EX, fwd_sel_a=01, fwd_sel_b=00.
REQ-031 SHALL cover a dependency at distance 2: add $3; nop; or $6,$3,$3 -> fwd_sel_a=fwd_sel_b=10.
REQ-032 SHALL cover double hit: add $3; add $3; sub $7,$3,$0 -> fwd_sel_a=01 (MEM priority), fwd_sel_b=00 ($0 never forwarded).
REQ-033 SHALL cover load-use: lw $2 in EX, ID add $4,$2,$1 -> stall_id=1 for one cycle, stall_count 0->1, bubble in EX; next cycle the add is in EX with fwd_sel_a=10.
REQ-034 SHALL cover flush during load-use: same as REQ-033 with flush=1 -> stall_id=0, stall_count unchanged, EX.valid=0 next cycle.
REQ-035 SHALL cover async reset mid-stream plus saturation: rst_n low between edges -> outputs 00/0/0 immediately; with CNT_W=2 and 5 stalls -> stall_count=3.
